// File: rtl/micro_pkg.sv
// micro_pkg: shared definitions for the micro_sequencer slice.
//   - microinstruction field positions/widths and the 36-bit MIR word width
//   - mir_t packed view of a microinstruction (MSB..LSB matches the word)
//   - state_t sequencer states {IDLE, RUN, HALTED}
//   - HALT_ADDR_DEFAULT, the reserved halt NEXT_ADDR value
//   - MIR_NOP, the all-zero microinstruction driven when not running
package micro_pkg;

    localparam int unsigned MIR_W     = 36;
    localparam int unsigned ADDR_W    = 9;
    localparam int unsigned UCYCLES_W = 16;

    localparam int unsigned NEXT_LSB  = 27;
    localparam int unsigned NEXT_W    = 9;
    localparam int unsigned JAM_LSB   = 24;
    localparam int unsigned JAM_W     = 3;
    localparam int unsigned SHIFT_LSB = 22;
    localparam int unsigned SHIFT_W   = 2;
    localparam int unsigned ALU_LSB   = 16;
    localparam int unsigned ALU_W     = 6;
    localparam int unsigned CSEL_LSB  = 7;
    localparam int unsigned CSEL_W    = 9;
    localparam int unsigned MEM_LSB   = 4;
    localparam int unsigned MEM_W     = 3;
    localparam int unsigned BSEL_LSB  = 0;
    localparam int unsigned BSEL_W    = 4;

    // Bit positions inside the JAM field {JMPC, JAMN, JAMZ}.
    localparam int unsigned JAM_JMPC  = 2;
    localparam int unsigned JAM_JAMN  = 1;
    localparam int unsigned JAM_JAMZ  = 0;

    localparam logic [ADDR_W-1:0] HALT_ADDR_DEFAULT = 9'h1FF;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } state_t;

    typedef struct packed {
        logic [NEXT_W-1:0]  next_addr;
        logic [JAM_W-1:0]   jam;
        logic [SHIFT_W-1:0] shift;
        logic [ALU_W-1:0]   alu;
        logic [CSEL_W-1:0]  c_sel;
        logic [MEM_W-1:0]   mem;
        logic [BSEL_W-1:0]  b_sel;
    } mir_t;

    localparam mir_t MIR_NOP = '0;

    function automatic mir_t mir_unpack(input logic [MIR_W-1:0] w);
        mir_t m;
        m.next_addr = w[NEXT_LSB  +: NEXT_W];
        m.jam       = w[JAM_LSB   +: JAM_W];
        m.shift     = w[SHIFT_LSB +: SHIFT_W];
        m.alu       = w[ALU_LSB   +: ALU_W];
        m.c_sel     = w[CSEL_LSB  +: CSEL_W];
        m.mem       = w[MEM_LSB   +: MEM_W];
        m.b_sel     = w[BSEL_LSB  +: BSEL_W];
        return m;
    endfunction

endpackage

// File: rtl/micro_sequencer_if.sv
// micro_sequencer_if: bundles the sequencer's load/start/flag inputs and its
// datapath-control outputs.
//   master : control-store loader / datapath side (drives load_*, start*, n, z[, mbr])
//   slave  : micro_sequencer
// Optional macro MICRO_JMPC_EN adds the 8-bit mbr input used by JMPC.
interface micro_sequencer_if;
    import micro_pkg::*;

    logic                 load_en;
    logic [ADDR_W-1:0]    load_addr;
    logic [MIR_W-1:0]     load_data;
    logic                 start;
    logic [ADDR_W-1:0]    start_addr;
    logic                 n;
    logic                 z;
`ifdef MICRO_JMPC_EN
    logic [7:0]           mbr;
`endif
    logic [ALU_W-1:0]     alu_opcode;
    logic [SHIFT_W-1:0]   shifter_opcode;
    logic [CSEL_W-1:0]    c_select;
    logic [BSEL_W-1:0]    b_select;
    logic [MEM_W-1:0]     mem_ctl;
    logic [ADDR_W-1:0]    mpc;
    logic                 busy;
    logic                 halted;
    logic [UCYCLES_W-1:0] ucycles;

`ifdef MICRO_JMPC_EN
    modport master (
        output load_en, load_addr, load_data, start, start_addr, n, z, mbr,
        input  alu_opcode, shifter_opcode, c_select, b_select, mem_ctl,
               mpc, busy, halted, ucycles
    );
    modport slave (
        input  load_en, load_addr, load_data, start, start_addr, n, z, mbr,
        output alu_opcode, shifter_opcode, c_select, b_select, mem_ctl,
               mpc, busy, halted, ucycles
    );
`else
    modport master (
        output load_en, load_addr, load_data, start, start_addr, n, z,
        input  alu_opcode, shifter_opcode, c_select, b_select, mem_ctl,
               mpc, busy, halted, ucycles
    );
    modport slave (
        input  load_en, load_addr, load_data, start, start_addr, n, z,
        output alu_opcode, shifter_opcode, c_select, b_select, mem_ctl,
               mpc, busy, halted, ucycles
    );
`endif

endinterface

// File: rtl/micro_next_addr.sv
// micro_next_addr: combinational next-microaddress unit.
//   next_addr : NEXT_ADDR field of the current MIR
//   jam       : {JMPC, JAMN, JAMZ}
//   n, z      : datapath flags for the current MIR operation
//   mbr       : memory byte register (only with MICRO_JMPC_EN)
//   addr      : next microaddress
// High bit is ORed with the taken JAM conditions, never added, so no wrap.
module micro_next_addr
    import micro_pkg::*;
(
    input  logic [NEXT_W-1:0] next_addr,
    input  logic [JAM_W-1:0]  jam,
    input  logic              n,
    input  logic              z,
`ifdef MICRO_JMPC_EN
    input  logic [7:0]        mbr,
`endif
    output logic [NEXT_W-1:0] addr
);

    logic              hi;
    logic [NEXT_W-2:0] lo;

`ifndef MICRO_JMPC_EN
    // JMPC has no effect in this build.
    logic unused_jmpc;
    assign unused_jmpc = jam[JAM_JMPC];
`endif

    always_comb begin
        hi = next_addr[NEXT_W-1] | (jam[JAM_JAMN] & n) | (jam[JAM_JAMZ] & z);
`ifdef MICRO_JMPC_EN
        lo = next_addr[NEXT_W-2:0] | (jam[JAM_JMPC] ? mbr : 8'h00);
`else
        lo = next_addr[NEXT_W-2:0];
`endif
        addr = {hi, lo};
    end

endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: microprogrammed controller with a loadable 512 x 36-bit
// control store and a microinstruction register (MIR).
//   clock : rising-edge clock
//   reset : synchronous, active-high; control-store contents are retained
//   bus   : micro_sequencer_if.slave
//           in  load_en/load_addr/load_data, start/start_addr, n, z[, mbr]
//           out alu_opcode, shifter_opcode, c_select, b_select, mem_ctl,
//               mpc, busy, halted, ucycles
// Optional macro MICRO_JMPC_EN enables JMPC (NEXT_ADDR[7:0] | mbr).
module micro_sequencer
    import micro_pkg::*;
#(
    parameter int unsigned          CS_ADDR_W = ADDR_W,
    parameter int unsigned          CS_DEPTH  = 512,
    parameter logic [CS_ADDR_W-1:0] HALT_ADDR = HALT_ADDR_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    micro_sequencer_if.slave bus
);

    if ((CS_DEPTH != (1 << CS_ADDR_W)) || (CS_ADDR_W != ADDR_W)) begin : g_bad_cfg
        $error("micro_sequencer: CS_DEPTH must equal 2**CS_ADDR_W and CS_ADDR_W must be 9");
    end

`ifdef MICRO_JMPC_EN
    localparam logic [JAM_W-1:0] JAM_MASK = 3'b111;
`else
    localparam logic [JAM_W-1:0] JAM_MASK = 3'b011;
`endif

    logic [MIR_W-1:0]     cstore [CS_DEPTH];

    state_t               state_q, state_d;
    mir_t                 mir_q, mir_d;
    logic [CS_ADDR_W-1:0] mpc_q, mpc_d;
    logic [UCYCLES_W-1:0] ucycles_q, ucycles_d;

    logic [CS_ADDR_W-1:0] seq_next;
    logic [CS_ADDR_W-1:0] rd_addr;
    logic [MIR_W-1:0]     cs_rd;
    logic                 cs_we;
    logic                 halt_hit;
    logic                 running;

    micro_next_addr u_next_addr (
        .next_addr (mir_q.next_addr),
        .jam       (mir_q.jam),
        .n         (bus.n),
        .z         (bus.z),
`ifdef MICRO_JMPC_EN
        .mbr       (bus.mbr),
`endif
        .addr      (seq_next)
    );

    assign running  = (state_q == RUN);
    // Halt word must carry no active jump; a masked-off JMPC does not count.
    assign halt_hit = (mir_q.next_addr == HALT_ADDR) && ((mir_q.jam & JAM_MASK) == '0);

    // One combinational read port: sequencing address in RUN, start address otherwise.
    assign rd_addr = running ? seq_next : bus.start_addr;
    assign cs_rd   = cstore[rd_addr];

    always_comb begin
        state_d   = state_q;
        mir_d     = mir_q;
        mpc_d     = mpc_q;
        ucycles_d = ucycles_q;
        cs_we     = 1'b0;
        unique case (state_q)
            IDLE, HALTED: begin
                cs_we = bus.load_en;
                if (bus.start) begin
                    state_d   = RUN;
                    mpc_d     = bus.start_addr;
                    ucycles_d = '0;
                    // Write-through: a same-edge write to the start address wins.
                    if (bus.load_en && (bus.load_addr == bus.start_addr)) begin
                        mir_d = mir_unpack(bus.load_data);
                    end else begin
                        mir_d = mir_unpack(cs_rd);
                    end
                end
            end
            RUN: begin
                if (ucycles_q != '1) begin
                    ucycles_d = ucycles_q + 1'b1;
                end
                if (halt_hit) begin
                    state_d = HALTED;
                    mir_d   = MIR_NOP;
                end else begin
                    mir_d = mir_unpack(cs_rd);
                    mpc_d = seq_next;
                end
            end
            default: begin
                state_d = IDLE;
                mir_d   = MIR_NOP;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            mir_q     <= MIR_NOP;
            mpc_q     <= '0;
            ucycles_q <= '0;
        end else begin
            state_q   <= state_d;
            mir_q     <= mir_d;
            mpc_q     <= mpc_d;
            ucycles_q <= ucycles_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && cs_we) begin
            cstore[bus.load_addr] <= bus.load_data;
        end
    end

    assign bus.alu_opcode     = running ? mir_q.alu   : '0;
    assign bus.shifter_opcode = running ? mir_q.shift : '0;
    assign bus.c_select       = running ? mir_q.c_sel : '0;
    assign bus.b_select       = running ? mir_q.b_sel : '0;
    assign bus.mem_ctl        = running ? mir_q.mem   : '0;
    assign bus.mpc            = mpc_q;
    assign bus.busy           = running;
    assign bus.halted         = (state_q == HALTED);
    assign bus.ucycles        = ucycles_q;

endmodule

// File: tb/tb_micro_sequencer.sv
module tb_micro_sequencer;

    localparam logic [8:0] HALT = 9'h1FF;

    typedef struct {
        string       nm;
        logic [8:0]  mpc;
        logic [5:0]  alu;
        logic [1:0]  sh;
        logic [8:0]  c;
        logic [3:0]  b;
        logic [2:0]  mem;
        logic [15:0] uc;
    } exp_t;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_bad;
    exp_t sb[$];
    exp_t e;
    logic [48:0] mon_act;
    logic [48:0] mon_req;

    micro_sequencer_if bus();

    micro_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [35:0] mk(input logic [8:0] nx, input logic [2:0] jam,
                                       input logic [1:0] sh, input logic [5:0] alu,
                                       input logic [8:0] c, input logic [2:0] mem,
                                       input logic [3:0] b);
        return {nx, jam, sh, alu, c, mem, b};
    endfunction

    task automatic push(input string nm, input logic [8:0] mpc, input logic [5:0] alu,
                        input logic [1:0] sh, input logic [8:0] c, input logic [3:0] b,
                        input logic [2:0] mem, input logic [15:0] uc);
        exp_t x;
        x.nm = nm; x.mpc = mpc; x.alu = alu; x.sh = sh; x.c = c; x.b = b; x.mem = mem; x.uc = uc;
        sb.push_back(x);
    endtask

    // Monitor: every cycle the DUT is issuing a microinstruction, pop and compare.
    always @(negedge clock) begin
        if (bus.busy === 1'b1) begin
            n_cmp++;
            mon_act = {bus.mpc, bus.alu_opcode, bus.shifter_opcode, bus.c_select,
                       bus.b_select, bus.mem_ctl, bus.ucycles};
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_issue: got mpc/alu/sh/c/b/mem/uc=%h with nothing expected", mon_act);
            end else begin
                e = sb.pop_front();
                mon_req = {e.mpc, e.alu, e.sh, e.c, e.b, e.mem, e.uc};
                if (mon_act !== mon_req) begin
                    n_bad++;
                    $display("FAIL %s: got mpc=%h alu=%b sh=%b c=%h b=%h mem=%b uc=%0d, want mpc=%h alu=%b sh=%b c=%h b=%h mem=%b uc=%0d",
                             e.nm, bus.mpc, bus.alu_opcode, bus.shifter_opcode, bus.c_select,
                             bus.b_select, bus.mem_ctl, bus.ucycles,
                             e.mpc, e.alu, e.sh, e.c, e.b, e.mem, e.uc);
                end
            end
        end
    end

    task automatic cyc(input int unsigned k);
        repeat (k) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic load_word(input logic [8:0] a, input logic [35:0] d);
        bus.load_en   = 1'b1;
        bus.load_addr = a;
        bus.load_data = d;
        cyc(1);
        bus.load_en   = 1'b0;
    endtask

    task automatic pulse_start(input logic [8:0] a);
        bus.start      = 1'b1;
        bus.start_addr = a;
        cyc(1);
        bus.start      = 1'b0;
    endtask

    task automatic check_status(input string nm, input logic exp_busy, input logic exp_halted,
                                input logic [15:0] exp_uc, input bit chk_mpc,
                                input logic [8:0] exp_mpc);
        logic [50:0] act;
        logic [50:0] req;
        act = {bus.alu_opcode, bus.shifter_opcode, bus.c_select, bus.b_select, bus.mem_ctl,
               bus.busy, bus.halted, bus.ucycles, (chk_mpc ? bus.mpc : 9'h000)};
        req = {6'h00, 2'b00, 9'h000, 4'h0, 3'b000,
               exp_busy, exp_halted, exp_uc, (chk_mpc ? exp_mpc : 9'h000)};
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got alu/sh/c/b/mem/busy/halted/uc/mpc=%h want %h", nm, act, req);
        end
    endtask

    task automatic wait_halted(input string nm, input logic [15:0] exp_uc);
        int unsigned k;
        k = 0;
        while (bus.halted !== 1'b1 && k < 64) begin
            cyc(1);
            k++;
        end
        if (bus.halted !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: halted=%b after %0d cycles, want 1", nm, bus.halted, k);
        end
        check_status({nm, "_halted"}, 1'b0, 1'b1, exp_uc, 1'b0, 9'h000);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL %s_drain: %0d expected issues left, want 0", nm, sb.size());
            sb.delete();
        end
    endtask

    typedef struct {
        logic [2:0] jam;
        logic       n;
        logic       z;
        logic [8:0] tgt;
    } jam_case_t;

    jam_case_t jc[6];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        bus.load_en = 1'b0; bus.load_addr = '0; bus.load_data = '0;
        bus.start = 1'b0; bus.start_addr = '0;
        bus.n = 1'b0; bus.z = 1'b0;
`ifdef MICRO_JMPC_EN
        bus.mbr = 8'h00;
`endif
        cyc(2);
        reset = 1'b0;

        // Reset / idle
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            check_status($sformatf("idle_%0d", i), 1'b0, 1'b0, 16'd0, 1'b1, 9'h000);
        end

        // Two-word program ending in halt
        load_word(9'h000, mk(9'h001, 3'b000, 2'b00, 6'b110001, 9'h100, 3'b000, 4'h0));
        load_word(9'h001, mk(HALT,   3'b000, 2'b00, 6'b111001, 9'h000, 3'b000, 4'h0));
        push("basic_w0", 9'h000, 6'b110001, 2'b00, 9'h100, 4'h0, 3'b000, 16'd0);
        push("basic_w1", 9'h001, 6'b111001, 2'b00, 9'h000, 4'h0, 3'b000, 16'd1);
        pulse_start(9'h000);
        wait_halted("basic", 16'd2);

        // Conditional jumps on n/z
        jc[0] = '{3'b001, 1'b0, 1'b1, 9'h110};
        jc[1] = '{3'b001, 1'b0, 1'b0, 9'h010};
        jc[2] = '{3'b010, 1'b1, 1'b0, 9'h110};
        jc[3] = '{3'b010, 1'b0, 1'b0, 9'h010};
        jc[4] = '{3'b011, 1'b1, 1'b1, 9'h110};
        jc[5] = '{3'b001, 1'b1, 1'b0, 9'h010};
        load_word(9'h010, mk(HALT, 3'b000, 2'b00, 6'h02, 9'h002, 3'b000, 4'h0));
        load_word(9'h110, mk(HALT, 3'b000, 2'b00, 6'h03, 9'h004, 3'b000, 4'h0));
        for (int i = 0; i < 6; i++) begin
            load_word(9'h005, mk(9'h010, jc[i].jam, 2'b00, 6'h05, 9'h001, 3'b000, 4'h0));
            bus.n = jc[i].n;
            bus.z = jc[i].z;
            push($sformatf("jam%0d_w0", i), 9'h005, 6'h05, 2'b00, 9'h001, 4'h0, 3'b000, 16'd0);
            push($sformatf("jam%0d_w1", i), jc[i].tgt, (jc[i].tgt == 9'h110) ? 6'h03 : 6'h02,
                 2'b00, (jc[i].tgt == 9'h110) ? 9'h004 : 9'h002, 4'h0, 3'b000, 16'd1);
            pulse_start(9'h005);
            wait_halted($sformatf("jam%0d", i), 16'd2);
        end
        bus.n = 1'b0;
        bus.z = 1'b0;

        // load_en / start during RUN are ignored
        load_word(9'h020, mk(9'h021, 3'b000, 2'b00, 6'h10, 9'h008, 3'b001, 4'h1));
        load_word(9'h021, mk(9'h022, 3'b000, 2'b01, 6'h11, 9'h010, 3'b010, 4'h2));
        load_word(9'h022, mk(9'h023, 3'b000, 2'b10, 6'h12, 9'h020, 3'b100, 4'h3));
        load_word(9'h023, mk(HALT,   3'b000, 2'b11, 6'h13, 9'h040, 3'b000, 4'h4));
        for (int r = 0; r < 2; r++) begin
            push($sformatf("run%0d_w0", r), 9'h020, 6'h10, 2'b00, 9'h008, 4'h1, 3'b001, 16'd0);
            push($sformatf("run%0d_w1", r), 9'h021, 6'h11, 2'b01, 9'h010, 4'h2, 3'b010, 16'd1);
            push($sformatf("run%0d_w2", r), 9'h022, 6'h12, 2'b10, 9'h020, 4'h3, 3'b100, 16'd2);
            push($sformatf("run%0d_w3", r), 9'h023, 6'h13, 2'b11, 9'h040, 4'h4, 3'b000, 16'd3);
            if (r == 0) begin
                bus.start      = 1'b1;
                bus.start_addr = 9'h020;
                cyc(1);
                bus.start_addr = 9'h005;
                bus.load_en    = 1'b1;
                bus.load_addr  = 9'h022;
                bus.load_data  = mk(HALT, 3'b000, 2'b00, 6'h3E, 9'h1FF, 3'b111, 4'hF);
                cyc(2);
                bus.start   = 1'b0;
                bus.load_en = 1'b0;
            end else begin
                pulse_start(9'h020);
            end
            wait_halted($sformatf("run%0d", r), 16'd4);
        end

        // Reset mid-RUN at mpc=3, then rerun
        load_word(9'h002, mk(9'h003, 3'b000, 2'b00, 6'h21, 9'h080, 3'b000, 4'h5));
        load_word(9'h003, mk(9'h004, 3'b000, 2'b00, 6'h22, 9'h040, 3'b000, 4'h6));
        load_word(9'h004, mk(HALT,   3'b000, 2'b00, 6'h23, 9'h020, 3'b000, 4'h7));
        push("abort_w2", 9'h002, 6'h21, 2'b00, 9'h080, 4'h5, 3'b000, 16'd0);
        push("abort_w3", 9'h003, 6'h22, 2'b00, 9'h040, 4'h6, 3'b000, 16'd1);
        pulse_start(9'h002);
        cyc(1);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        check_status("abort_idle", 1'b0, 1'b0, 16'd0, 1'b1, 9'h000);
        push("rerun_w2", 9'h002, 6'h21, 2'b00, 9'h080, 4'h5, 3'b000, 16'd0);
        push("rerun_w3", 9'h003, 6'h22, 2'b00, 9'h040, 4'h6, 3'b000, 16'd1);
        push("rerun_w4", 9'h004, 6'h23, 2'b00, 9'h020, 4'h7, 3'b000, 16'd2);
        pulse_start(9'h002);
        wait_halted("rerun", 16'd3);

        // Same-edge load and start at one address: write-through
        push("bypass", 9'h040, 6'h2A, 2'b10, 9'h001, 4'h7, 3'b101, 16'd0);
        bus.load_en    = 1'b1;
        bus.load_addr  = 9'h040;
        bus.load_data  = mk(HALT, 3'b000, 2'b10, 6'h2A, 9'h001, 3'b101, 4'h7);
        bus.start      = 1'b1;
        bus.start_addr = 9'h040;
        cyc(1);
        bus.load_en = 1'b0;
        bus.start   = 1'b0;
        wait_halted("bypass", 16'd1);

        // JMPC word: dispatch on mbr when enabled, plain NEXT_ADDR otherwise
        load_word(9'h007, mk(9'h100, 3'b100, 2'b00, 6'h07, 9'h002, 3'b000, 4'h0));
        load_word(9'h12A, mk(HALT,   3'b000, 2'b00, 6'h3F, 9'h004, 3'b000, 4'h0));
        load_word(9'h100, mk(HALT,   3'b000, 2'b00, 6'h30, 9'h008, 3'b000, 4'h0));
        push("jmpc_w0", 9'h007, 6'h07, 2'b00, 9'h002, 4'h0, 3'b000, 16'd0);
`ifdef MICRO_JMPC_EN
        bus.mbr = 8'h2A;
        push("jmpc_w1", 9'h12A, 6'h3F, 2'b00, 9'h004, 4'h0, 3'b000, 16'd1);
`else
        push("jmpc_w1", 9'h100, 6'h30, 2'b00, 9'h008, 4'h0, 3'b000, 16'd1);
`endif
        pulse_start(9'h007);
        wait_halted("jmpc", 16'd2);

        cyc(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Microprogrammed controller for the 32-bit register/ALU/shifter datapath.
- Holds a loadable 512 x 36-bit control store and a microinstruction register (MIR).
- Each cycle it drives alu_opcode, shifter_opcode, c_select, b_select and mem_ctl from the MIR.
- Computes the next microaddress from NEXT_ADDR plus conditional jumps on the datapath n/z flags.

Parameters:
- CS_ADDR_W, 9, control-store address width.
- CS_DEPTH, 512, control-store words; must equal 2**CS_ADDR_W.
- HALT_ADDR, 9'h1FF, reserved NEXT_ADDR value that signals halt.

Ports:
- clock  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- load_en  input  1  control-store write strobe.
- load_addr  input  9  write address.
- load_data  input  36  microinstruction word to write.
- start  input  1  single-cycle pulse that begins execution.
- start_addr  input  9  first microaddress.
- n  input  1  datapath negative flag for the current MIR operation.
- z  input  1  datapath zero flag for the current MIR operation.
- alu_opcode  output  6  ALU function.
- shifter_opcode  output  2  shifter function.
- c_select  output  9  one-hot C-bus write enables; 0 means no write.
- b_select  output  4  B-bus source.
- mem_ctl  output  3  memory read/write/fetch controls.
- mpc  output  9  address of the word currently in the MIR.
- busy  output  1  high in RUN.
- halted  output  1  high in HALTED.
- ucycles  output  16  count of issued microinstructions, saturating.

Behaviour:
- Word layout: [35:27] NEXT_ADDR, [26:24] JAM {JMPC,JAMN,JAMZ}, [23:22] shifter, [21:16] alu, [15:7] c_select, [6:4] mem, [3:0] b_select.
- States: IDLE, RUN, HALTED.
- Reset:
  - State goes to IDLE; MIR=0, mpc=0, ucycles=0.
  - All outputs 0; busy=0, halted=0.
  - Control-store contents are not reset and are retained.
- Outputs are MIR fields in RUN only; in IDLE/HALTED every opcode/select output is forced to 0 (NOP).
- IDLE or HALTED:
  - load_en=1 writes cstore[load_addr]=load_data at the edge.
  - start=1 loads MIR=cstore[start_addr] and mpc=start_addr, clears ucycles, enters RUN.
  - First microinstruction drives the outputs in the cycle after the start edge (1-cycle latency).
  - halted clears on start.
- load_en and start together, same address: MIR receives load_data (write-through bypass).
- RUN, each edge:
  - next = {NEXT_ADDR[8] | (JAMN & n) | (JAMZ & z), NEXT_ADDR[7:0]}.
  - MIR=cstore[next], mpc=next; combinational control-store read.
  - ucycles increments and saturates at 16'hFFFF.
  - n/z are sampled at the edge ending the cycle whose MIR carries JAMN/JAMZ.
- Halt:
  - In RUN, a MIR with NEXT_ADDR==HALT_ADDR and JAM==0 is issued for its full cycle and counted.
  - Next edge: HALTED, MIR cleared.
- In RUN, load_en and start are ignored (no write, no restart).
- Address wrap is impossible: next is 9-bit, bit 8 OR only.
- JAMN=JAMZ=1 with n=z=1 gives a single OR, not an add.
- reset during RUN aborts at that edge; outputs are NOP the following cycle.

Optional Feature:
- Macro: MICRO_JMPC_EN.
- Defined:
  - Adds port mbr input 8 (memory byte register).
  - When JMPC=1: next = {high bit from the JAM rule above, NEXT_ADDR[7:0] | mbr}.
- Undefined:
  - Port is absent and JAM[2] is ignored.
  - A word with JMPC set behaves as JMPC=0.

Decomposition:
- Shared package micro_pkg holds:
  - Field bit positions and widths.
  - MIR word width 36.
  - State enum {IDLE, RUN, HALTED}.
  - HALT_ADDR default.
  - NOP constant.
- Natural sub-module: micro_next_addr, the combinational next-address unit (NEXT_ADDR, JAM, n, z, optional mbr in; 9-bit address out).
- Control-store array and FSM stay in micro_sequencer.

Test Plan:
- Reset, then idle 3 cycles -> all outputs 0, busy=0, halted=0, ucycles=0.
- Load addr 0: alu=6'b110001, c=9'h100, NEXT=1; load addr 1: alu=6'b111001, NEXT=HALT_ADDR; pulse start_addr=0 -> cycle1 alu=110001/c=100, cycle2 alu=111001, then halted=1, outputs 0, ucycles=2.
- Word at 5 with JAMZ, NEXT=0x010: z=1 -> mpc=0x110; z=0 -> mpc=0x010; repeat with JAMN/n.
- load_en and start in RUN -> control store unchanged (readback via a later run), execution continues uninterrupted.
- reset asserted mid-RUN at mpc=3 -> next cycle IDLE, NOP outputs; stored program reruns identically after start.
- MICRO_JMPC_EN defined: JMPC word with NEXT=0x100, mbr=8'h2A -> mpc=0x12A.
